// File: rtl/resp_delay_check.sv
// rtl/resp_delay_check.sv - response delay pipeline with antecedent |-> ##DEPTH consequent checker
// Violations are latched sticky per channel and counted with saturation.
module resp_delay_check #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] antecedent,
    input  logic                stall,
    input  logic [CHANNELS-1:0] mask,
    input  logic                clear,
    output logic [CHANNELS-1:0] consequent,
    output logic [CHANNELS-1:0] fail_vec,
    output logic [CNT_W-1:0]    fail_count
);

    // Six extra bits cover adding up to 32 violations before saturation.
    localparam int SUM_W = CNT_W + 6;

    logic [CHANNELS-1:0] stage_q [DEPTH];
    logic [CHANNELS-1:0] fail_vec_q;
    logic [CHANNELS-1:0] fail_vec_d;
    logic [CHANNELS-1:0] viol;
    logic [CNT_W-1:0]    fail_count_q;
    logic [CNT_W-1:0]    fail_count_d;
    logic [5:0]          viol_cnt;
    logic [SUM_W-1:0]    sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (!stall) begin
            stage_q[0] <= antecedent;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign consequent = stage_q[DEPTH-1] & ~mask;

    // A due response suppressed by the mask is the only way consequent can miss.
    always_comb begin
        viol     = stall ? '0 : (stage_q[DEPTH-1] & mask);
        viol_cnt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            viol_cnt = viol_cnt + 6'(viol[c]);
        end
        sum = (clear ? '0 : SUM_W'(fail_count_q)) + SUM_W'(viol_cnt);
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            fail_count_d = '1;
        end else begin
            fail_count_d = sum[CNT_W-1:0];
        end
        fail_vec_d = clear ? viol : (fail_vec_q | viol);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_vec_q   <= '0;
            fail_count_q <= '0;
        end else begin
            fail_vec_q   <= fail_vec_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign fail_vec   = fail_vec_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_resp_delay_check.sv
// tb/tb_resp_delay_check.sv - self-checking bench for resp_delay_check
module tb_resp_delay_check;

    localparam int CH   = 4;
    localparam int DP   = 3;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] antecedent;
    logic          stall;
    logic [CH-1:0] mask;
    logic          clear;
    logic [CH-1:0] consequent;
    logic [CH-1:0] fail_vec;
    logic [CW-1:0] fail_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: every antecedent accepted on an advancing edge, in order.
    logic [CH-1:0] hist [$];
    logic [CH-1:0] m_fv;
    int            m_cnt;

    resp_delay_check #(.CHANNELS(CH), .DEPTH(DP), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .antecedent (antecedent),
        .stall      (stall),
        .mask       (mask),
        .clear      (clear),
        .consequent (consequent),
        .fail_vec   (fail_vec),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH-1:0] model_out();
        if (hist.size() >= DP) return hist[hist.size() - DP];
        return '0;
    endfunction

    // Called shortly after a rising edge; leaves time just after the next rising edge.
    task automatic cycle(input logic [CH-1:0] a, input logic s, input logic [CH-1:0] m, input logic c);
        logic [CH-1:0] due;
        logic [CH-1:0] v;
        int            n;
        antecedent = a;
        stall      = s;
        mask       = m;
        clear      = c;
        #1;
        due = model_out();
        check("consequent", 32'(consequent), 32'(due & ~m));
        v = s ? '0 : (due & m);
        n = $countones(v);
        if (c) begin
            m_fv  = v;
            m_cnt = (n > MAXC) ? MAXC : n;
        end else begin
            m_fv  = m_fv | v;
            m_cnt = (m_cnt + n > MAXC) ? MAXC : m_cnt + n;
        end
        if (!s) begin
            hist.push_back(a);
            if (hist.size() > DP) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
        check("fail_vec", 32'(fail_vec), 32'(m_fv));
        check("fail_count", 32'(fail_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        hist.delete();
        m_fv  = '0;
        m_cnt = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must drop without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_consequent", 32'(consequent), 32'h0);
        check("rst_fail_vec", 32'(fail_vec), 32'h0);
        check("rst_fail_count", 32'(fail_count), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        antecedent = '0;
        stall      = 1'b0;
        mask       = '0;
        clear      = 1'b0;
        reset      = 1'b1;
        model_reset();
        #3;
        check("init_consequent", 32'(consequent), 32'h0);
        check("init_fail_vec", 32'(fail_vec), 32'h0);
        check("init_fail_count", 32'(fail_count), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Plain pulse, then the same pulse with a two-cycle stall mid-flight.
        cycle(4'b0101, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) cycle(4'h0, 0, 4'h0, 0);
        cycle(4'b0101, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'h0, 1, 4'h0, 0);
        cycle(4'h0, 1, 4'hF, 0);
        for (int i = 0; i < 3; i++) cycle(4'h0, 0, 4'h0, 0);
        check("stall_no_fail", 32'(fail_count), 32'h0);

        // Partial mask when the pulse is due.
        cycle(4'hF, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'b0011, 0);
        check("mask_fail_vec", 32'(fail_vec), 32'h3);
        check("mask_fail_count", 32'(fail_count), 32'h2);

        // Saturation, then a clear with nothing new failing.
        for (int i = 0; i < 70; i++) cycle(4'hF, 0, 4'hF, 0);
        check("sat_count", 32'(fail_count), 32'(MAXC));
        cycle(4'h0, 0, 4'h0, 1);
        check("clear_fail_vec", 32'(fail_vec), 32'h0);
        check("clear_fail_count", 32'(fail_count), 32'h0);

        // Request in flight discarded by reset.
        for (int i = 0; i < 3; i++) cycle(4'h0, 0, 4'h0, 0);
        cycle(4'b1010, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        async_reset();
        for (int i = 0; i < 4; i++) cycle(4'h0, 0, 4'hF, 0);
        check("post_rst_count", 32'(fail_count), 32'h0);

        // Clear coinciding with a single-channel violation while count is 5.
        cycle(4'hF, 0, 4'h0, 0);
        cycle(4'b0001, 0, 4'h0, 0);
        cycle(4'b0100, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'hF, 0);
        cycle(4'h0, 0, 4'hF, 0);
        check("pre_clear_count", 32'(fail_count), 32'h5);
        cycle(4'h0, 0, 4'hF, 1);
        check("clr_viol_count", 32'(fail_count), 32'h1);
        check("clr_viol_vec", 32'(fail_vec), 32'h4);

        // Stall together with clear: clear acts, nothing recorded.
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'hF, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'h0, 0, 4'h0, 0);
        cycle(4'h0, 1, 4'hF, 1);
        check("stall_clear_count", 32'(fail_count), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if (i % 173 == 172) begin
                async_reset();
            end else begin
                cycle(CH'($urandom),
                      ($urandom_range(0, 3) == 0),
                      CH'($urandom & $urandom & $urandom),
                      ($urandom_range(0, 15) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/resp_delay_check.md
RESP_DELAY_CHECK -- requirements
Module: resp_delay_check

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent antecedent/consequent channels, legal range 1..32.
REQ-002 Parameter DEPTH, default 3: response latency in advancing cycles, legal range 1..16.
REQ-003 Parameter CNT_W, default 8: width of the failure counter, legal range 1..16.
REQ-004 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port antecedent  input  CHANNELS: per-channel request bits, sampled on advancing cycles.
REQ-007 Port stall  input  1: when high, the pipeline and checker hold state (non-advancing cycle).
REQ-008 Port mask  input  CHANNELS: fault-injection; a high bit forces that consequent bit low.
REQ-009 Port clear  input  1: synchronous clear of fail_vec and fail_count.
REQ-010 Port consequent  output  CHANNELS: delayed response bits.
REQ-011 Port fail_vec  output  CHANNELS: sticky per-channel property-violation flags.
REQ-012 Port fail_count  output  CNT_W: saturating count of violations.

Function
REQ-013 The block SHALL hold a pipeline stage[0..DEPTH-1], each CHANNELS bits wide.
REQ-014 On an advancing cycle (stall low), stage[0] SHALL load antecedent, and each stage[i] SHALL load stage[i-1] for i from 1 to DEPTH-1.
REQ-015 On a stalled cycle, all stages SHALL hold their values.
REQ-016 consequent SHALL equal stage[DEPTH-1] & ~mask, combinationally.
REQ-017 Latency: antecedent high at advancing cycle t SHALL appear on consequent after exactly DEPTH advancing edges, with stalled cycles not counted.
REQ-018 A violation on channel c SHALL be stage[DEPTH-1][c]=1 and consequent[c]=0, evaluated only on advancing cycles (property antecedent |-> ##DEPTH consequent, disabled during reset).
REQ-019 A violation SHALL set fail_vec[c] at the next clock edge, and fail_vec[c] SHALL remain set until clear or reset.
REQ-020 fail_count SHALL add the number of channels violating in that cycle (0..CHANNELS) at the same edge.
REQ-021 fail_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 clear high SHALL zero fail_vec and fail_count at the next edge.
REQ-023 If clear and violations coincide, violations in that same cycle SHALL still be recorded: fail_vec takes the failing bits, and fail_count takes their count, saturated.
REQ-024 A stalled cycle with a mask bit high SHALL NOT record a violation.
REQ-025 Channels SHALL be fully independent; no cross-channel ordering or interaction.
REQ-026 stall and clear together: clear SHALL act, and no violation SHALL be recorded.

Reset
REQ-027 Asserting reset SHALL immediately, without a clock, zero all stages, fail_vec and fail_count; consequent becomes 0.
REQ-028 Requests in flight when reset asserts SHALL be discarded; no violation SHALL be reported for them after reset releases.
REQ-029 After reset deasserts, the first advancing edge SHALL load stage[0] normally; outputs SHALL be 0 until data has propagated through the pipeline.

Verification (CHANNELS=4, DEPTH=3, CNT_W=8)
REQ-030 Drive antecedent=4'b0101 for one cycle, with stall=0 and mask=0 -> consequent=4'b0101 exactly 3 edges later, then 0; fail_vec=0 and fail_count=0.
REQ-031 Same pulse with stall high for 2 cycles mid-flight -> consequent=4'b0101 after 5 edges; no violation.
REQ-032 antecedent=4'b1111 pulse, with mask=4'b0011 held when the pulse reaches stage 2 -> consequent=4'b1100; next edge fail_vec=4'b0011 and fail_count=2.
REQ-033 Saturation test: mask=4'b1111 with antecedent=4'b1111 continuously for 70 cycles -> fail_count stops at 255; then pulse clear with no new failures -> fail_vec=0 and fail_count=0.
REQ-034 Reset test: assert reset asynchronously between edges with 4'b1010 in stage 1 -> consequent and all flags 0 at once; after release, no violation and no consequent for that request.
REQ-035 Clear coinciding with a one-channel violation and fail_count=5 -> next edge fail_count=1 and fail_vec shows only that channel.
